// File: rtl/mem_access.sv
// Memory-access stage: one request/acknowledge data-memory transaction per instruction,
// with byte/half/word lane steering and load extension. Optional watchdog: MEM_TIMEOUT_EN.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Read_data_2,
  input  logic        Controller_memread,
  input  logic        Controller_memwrite,
  input  logic [1:0]  Controller_memsize,
  input  logic        Controller_memsigned,
  input  logic        ALU_kick_up,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] MEM_result,
  output logic        MEM_kick_up,
  output logic        MEM_misaligned,
  output logic        MEM_timeout,
  output logic        MEM_busy
);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_next;

  logic        is_mem, misaligned, accept, quick_done, start_req, abort;
  logic [1:0]  cap_off, cap_size;
  logic        cap_signed, cap_write;
  logic [31:0] cap_result, load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign is_mem     = Controller_memread | Controller_memwrite;
  assign misaligned = is_mem && ((Controller_memsize == 2'b01 && ALU_result[0]) ||
                                 (Controller_memsize[1] && ALU_result[1:0] != 2'b00));
  assign accept     = (state == IDLE) && ALU_kick_up;
  assign quick_done = accept && (!is_mem || misaligned);
  assign start_req  = accept && is_mem && !misaligned;
  assign dmem_req   = (state == REQ);
  assign MEM_busy   = (state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_req) state_next = REQ;
      REQ:  if (dmem_ack || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_lane = 8'(dmem_rdata >> {cap_off, 3'b000});
    half_lane = 16'(dmem_rdata >> {cap_off[1], 4'b0000});
    case (cap_size)
      2'b00:   load_val = {{24{cap_signed & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{cap_signed & half_lane[15]}}, half_lane};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      MEM_result     <= '0;
      MEM_kick_up    <= 1'b0;
      MEM_misaligned <= 1'b0;
      cap_off        <= '0;
      cap_size       <= '0;
      cap_signed     <= 1'b0;
      cap_write      <= 1'b0;
      cap_result     <= '0;
    end else begin
      MEM_kick_up <= 1'b0;
      if (accept) begin
        cap_off    <= ALU_result[1:0];
        cap_size   <= Controller_memsize;
        cap_signed <= Controller_memsigned;
        cap_write  <= Controller_memwrite;
        cap_result <= ALU_result;
        if (!is_mem) begin
          MEM_result     <= ALU_result;
          MEM_misaligned <= 1'b0;
          MEM_kick_up    <= 1'b1;
        end else if (misaligned) begin
          MEM_result     <= '0;
          MEM_misaligned <= 1'b1;
          MEM_kick_up    <= 1'b1;
        end else begin
          dmem_we   <= Controller_memwrite;
          dmem_addr <= {ALU_result[31:2], 2'b00};
          case (Controller_memsize)
            2'b00: begin
              dmem_wdata <= {4{Read_data_2[7:0]}};
              dmem_be    <= 4'b0001 << ALU_result[1:0];
            end
            2'b01: begin
              dmem_wdata <= {2{Read_data_2[15:0]}};
              dmem_be    <= ALU_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
              dmem_wdata <= Read_data_2;
              dmem_be    <= 4'b1111;
            end
          endcase
        end
      end else if (state == REQ) begin
        // Ack outranks a watchdog expiry in the same cycle
        if (dmem_ack) begin
          MEM_result     <= cap_write ? cap_result : load_val;
          MEM_misaligned <= 1'b0;
          MEM_kick_up    <= 1'b1;
        end else if (abort) begin
          MEM_result     <= '0;
          MEM_misaligned <= 1'b0;
          MEM_kick_up    <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wd_cnt;

  assign abort = (state == REQ) && !dmem_ack && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      MEM_timeout <= 1'b0;
    end else begin
      if (start_req)
        wd_cnt <= '0;
      else if (state == REQ && !dmem_ack)
        wd_cnt <= wd_cnt + 8'd1;
      if (quick_done || (state == REQ && dmem_ack))
        MEM_timeout <= 1'b0;
      else if (abort)
        MEM_timeout <= 1'b1;
    end
  end
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT_CYCLES);
  assign abort       = 1'b0;
  assign MEM_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios then randomized transactions
// checked against an arithmetic reference model of lane steering and load extension.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ALU_result = '0, Read_data_2 = '0, dmem_rdata = '0;
  logic        Controller_memread = 1'b0, Controller_memwrite = 1'b0;
  logic [1:0]  Controller_memsize = '0;
  logic        Controller_memsigned = 1'b0, ALU_kick_up = 1'b0, dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, MEM_kick_up, MEM_misaligned, MEM_timeout, MEM_busy;
  logic [31:0] dmem_addr, dmem_wdata, MEM_result;
  logic [3:0]  dmem_be;

  int tests = 0;
  int fails = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ALU_result(ALU_result), .Read_data_2(Read_data_2),
    .Controller_memread(Controller_memread), .Controller_memwrite(Controller_memwrite),
    .Controller_memsize(Controller_memsize), .Controller_memsigned(Controller_memsigned),
    .ALU_kick_up(ALU_kick_up), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .MEM_result(MEM_result),
    .MEM_kick_up(MEM_kick_up), .MEM_misaligned(MEM_misaligned),
    .MEM_timeout(MEM_timeout), .MEM_busy(MEM_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: kick, optional bus phase with wait_cyc wait cycles, completion checks.
  task automatic run(input logic [31:0] a, input logic [31:0] rs2, input logic rd,
                     input logic wr, input logic [1:0] sz, input logic sg,
                     input int wait_cyc, input logic [31:0] rdata, input logic poke);
    int          off, v;
    logic        mem, mis;
    logic [31:0] exp_be, exp_wd, exp_res;
    off = int'(a % 4);
    mem = rd | wr;
    mis = mem && ((sz == 2'd1 && off % 2 == 1) || (sz >= 2'd2 && off != 0));
    if (sz == 2'd0) begin
      exp_be = 32'(1 << off);
      exp_wd = (rs2 % 256) * 32'h0101_0101;
      v = int'((rdata >> (8 * off)) % 256);
      if (sg && v >= 128) v = v - 256;
      exp_res = 32'(v);
    end else if (sz == 2'd1) begin
      exp_be = (off >= 2) ? 32'd12 : 32'd3;
      exp_wd = (rs2 % 65536) * 32'h0001_0001;
      v = int'((rdata >> (16 * (off / 2))) % 65536);
      if (sg && v >= 32768) v = v - 65536;
      exp_res = 32'(v);
    end else begin
      exp_be = 32'd15;
      exp_wd = rs2;
      exp_res = rdata;
    end
    if (!mem) exp_res = a;
    else if (mis) exp_res = 0;
    else if (wr) exp_res = a;

    @(negedge clk);
    ALU_result = a; Read_data_2 = rs2; Controller_memread = rd; Controller_memwrite = wr;
    Controller_memsize = sz; Controller_memsigned = sg; ALU_kick_up = 1'b1;
    tick();
    ALU_kick_up = 1'b0;
    if (!mem || mis) begin
      check("quick_req", 32'(dmem_req), 0);
    end else begin
      check("req_start", 32'(dmem_req), 1);
      check("req_we", 32'(dmem_we), 32'(wr));
      check("req_addr", dmem_addr, a - 32'(off));
      check("req_be", 32'(dmem_be), exp_be);
      if (wr) check("req_wdata", dmem_wdata, exp_wd);
      for (int i = 0; i < wait_cyc; i++) begin
        if (poke && i == 0) begin
          ALU_kick_up = 1'b1; ALU_result = 32'hBAD0_BAD0;
          Controller_memread = 1'b0; Controller_memwrite = 1'b0;
        end
        tick();
        ALU_kick_up = 1'b0;
        check("wait_req", 32'(dmem_req), 1);
        check("wait_busy", 32'(MEM_busy), 1);
        check("wait_kick", 32'(MEM_kick_up), 0);
        check("wait_addr", dmem_addr, a - 32'(off));
        check("wait_be", 32'(dmem_be), exp_be);
        if (wr) check("wait_wdata", dmem_wdata, exp_wd);
      end
      dmem_ack = 1'b1;
      dmem_rdata = rdata;
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      check("done_req", 32'(dmem_req), 0);
    end
    check("done_kick", 32'(MEM_kick_up), 1);
    check("done_result", MEM_result, exp_res);
    check("done_mis", 32'(MEM_misaligned), 32'(mis));
    check("done_timeout", 32'(MEM_timeout), 0);
    tick();
    check("pulse_width", 32'(MEM_kick_up), 0);
    check("hold_result", MEM_result, exp_res);
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_kick", 32'(MEM_kick_up), 0);
    check("rst_result", MEM_result, 0);
    check("rst_busy", 32'(MEM_busy), 0);
    @(negedge clk);
    reset = 1'b1;

    run(32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    run(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2, 32'h80AA_BBCC, 1'b0);
    run(32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1, 32'h0, 1'b0);
    run(32'h0000_3001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    run(32'h0000_00AA, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0, 1'b0);
    run(32'h0000_4002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 0, 32'h8001_7FFF, 1'b0);
    run(32'h0000_4000, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, 3, 32'hCAFE_F00D, 1'b1);
    run(32'h0000_5003, 32'h0000_0077, 1'b1, 1'b1, 2'd0, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    ALU_result = 32'h0000_6000; Controller_memread = 1'b1; Controller_memwrite = 1'b0;
    Controller_memsize = 2'd2; ALU_kick_up = 1'b1;
    tick();
    ALU_kick_up = 1'b0;
    check("rstmid_req_before", 32'(dmem_req), 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_req", 32'(dmem_req), 0);
    check("rstmid_busy", 32'(MEM_busy), 0);
    check("rstmid_result", MEM_result, 0);
    dmem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("rstmid_kick", 32'(MEM_kick_up), 0);
    check("rstmid_req_after", 32'(dmem_req), 0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    ALU_result = 32'h0000_7000; Controller_memread = 1'b1; Controller_memsize = 2'd2;
    ALU_kick_up = 1'b1;
    tick();
    ALU_kick_up = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      cnt++;
      tick();
    end
    check("to_cycles", 32'(cnt), 4);
    check("to_kick", 32'(MEM_kick_up), 1);
    check("to_flag", 32'(MEM_timeout), 1);
    check("to_result", MEM_result, 0);
    tick();
    check("to_pulse", 32'(MEM_kick_up), 0);
    run(32'h0000_0042, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0, 1'b0);
`else
    cnt = 0;
`endif

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run(a, $urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
